// File: rtl/ezlogic_stream_cipher.sv
// ezlogic_stream_cipher
//   Byte-stream obfuscation engine. Each accepted byte d is turned into one
//   output byte o = rotl(d ^ s, ROT) + idx. The chaining state s takes the
//   ciphertext o, and idx is the byte position within the frame. Both reload
//   (s = SEED, idx = 0) after LEN accepted bytes. Latency is one cycle, and
//   the engine accepts one byte per cycle with no backpressure.
//
//   Optional build macro: EZLOGIC_FRAME_DONE_EN
//     Adds frame_done, a one-cycle pulse that is high together with the
//     valid_out of the last byte of each frame. Also adds frame_crc, which
//     holds the XOR of all output bytes of the last completed frame.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   data_in    input byte
//   valid_in   data_in valid this cycle
//   data_out   transformed byte (holds its value between strobes)
//   valid_out  one-cycle strobe per output byte
//   frame_done (macro only) last byte of frame on data_out
//   frame_crc  (macro only) XOR of the last completed frame's output bytes
module ezlogic_stream_cipher #(
  parameter int unsigned LEN  = 42,     // bytes per frame, 1..64
  parameter logic [7:0]  SEED = 8'h5A,  // chaining state at frame start
  parameter int unsigned ROT  = 3       // left-rotate amount, 0..7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out
`ifdef EZLOGIC_FRAME_DONE_EN
  ,
  output logic       frame_done,
  output logic [7:0] frame_crc
`endif
);

  localparam logic [5:0] LAST_IDX = 6'(LEN - 1);
  localparam int unsigned ROT_R   = 8 - ROT;

  logic [7:0] s;
  logic [5:0] idx;
  logic [7:0] t;
  logic [7:0] r;
  logic [7:0] o;
  logic       last;

  // The shifts are evaluated at 8-bit width, so the bits shifted out of the
  // left shift are dropped. OR-ing the two halves therefore gives a true
  // rotate. When ROT = 0, the right shift by 8 contributes nothing.
  always_comb begin
    t    = data_in ^ s;
    r    = (t << ROT) | (t >> ROT_R);
    o    = r + {2'b00, idx};
    last = (idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= SEED;
      idx       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= o;
        // The frame-boundary reload takes priority over ciphertext chaining.
        if (last) begin
          idx <= '0;
          s   <= SEED;
        end else begin
          idx <= idx + 6'd1;
          s   <= o;
        end
      end
    end
  end

`ifdef EZLOGIC_FRAME_DONE_EN
  // crc_acc collects the XOR of the bytes of the frame in progress. When the
  // last byte arrives, it is folded in and the result is published.
  logic [7:0] crc_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc    <= '0;
      frame_crc  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= valid_in & last;
      if (valid_in) begin
        if (last) begin
          frame_crc <= crc_acc ^ o;
          crc_acc   <= '0;
        end else begin
          crc_acc   <= crc_acc ^ o;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ezlogic_stream_cipher.sv
// Self-checking bench for ezlogic_stream_cipher. It drives directed test-plan
// scenarios and a randomized stream. Every scenario is checked against a
// behavioural reference model built from the cipher rules.
module tb_ezlogic_stream_cipher;

  localparam int unsigned LEN  = 42;
  localparam logic [7:0]  SEED = 8'h5A;
  localparam int unsigned ROT  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
`ifdef EZLOGIC_FRAME_DONE_EN
  logic       frame_done;
  logic [7:0] frame_crc;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         m_s;
  int         m_pos;
  logic [7:0] m_do;
  logic       m_vo;
  logic       m_fd;
  logic [7:0] m_acc;
  logic [7:0] m_crc;

  ezlogic_stream_cipher #(.LEN(LEN), .SEED(SEED), .ROT(ROT)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out)
`ifdef EZLOGIC_FRAME_DONE_EN
    ,
    .frame_done(frame_done),
    .frame_crc (frame_crc)
`endif
  );

  always #5 clk = ~clk;

  // Cipher rule expressed with integer arithmetic.
  function automatic logic [7:0] enc(input int d, input int s, input int pos);
    int t;
    int r;
    t = (d ^ s) & 255;
    r = ((t << ROT) | (t >> (8 - ROT))) & 255;
    return 8'((r + pos) % 256);
  endfunction

  // Apply one cycle of stimulus. Outputs are sampled 1 time unit after the
  // edge, and the model is advanced to match that edge.
  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    logic [7:0] o;
    rst = r; valid_in = v; data_in = d;
    @(posedge clk); #1;
    if (r) begin
      m_s = SEED; m_pos = 0; m_do = 8'h00; m_vo = 1'b0;
      m_fd = 1'b0; m_acc = 8'h00; m_crc = 8'h00;
    end else if (v) begin
      o = enc(d, m_s, m_pos);
      m_do = o; m_vo = 1'b1;
      m_fd = (m_pos == LEN - 1);
      if (m_fd) begin
        m_crc = m_acc ^ o; m_acc = 8'h00; m_s = SEED; m_pos = 0;
      end else begin
        m_acc = m_acc ^ o; m_s = o; m_pos = m_pos + 1;
      end
    end else begin
      m_vo = 1'b0; m_fd = 1'b0;
    end
    rst = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    vectors++;
    if (data_out !== 8'h00 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got data=%h valid=%b exp data=00 valid=0", data_out, valid_out);
    end
`ifdef EZLOGIC_FRAME_DONE_EN
    vectors++;
    if (frame_done !== 1'b0 || frame_crc !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_fd got done=%b crc=%h exp 0 00", frame_done, frame_crc);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] din [3]  = '{8'h30, 8'h6F, 8'h70};
    logic [7:0] dexp [3] = '{8'h53, 8'hE2, 8'h96};
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, din[i]);
      vectors++;
      if (valid_out !== 1'b1 || data_out !== dexp[i] || data_out !== m_do) begin
        miscompares++;
        $display("FAIL b2b[%0d] got data=%h valid=%b exp data=%h valid=1",
                 i, data_out, valid_out, dexp[i]);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end got valid=%b exp 0", valid_out);
    end
  endtask

  task automatic test_single_idle();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    vectors++;
    if (valid_out !== 1'b1 || data_out !== 8'hD2) begin
      miscompares++;
      $display("FAIL single got data=%h valid=%b exp data=d2 valid=1", data_out, valid_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'($urandom));
      vectors++;
      if (valid_out !== 1'b0 || data_out !== 8'hD2) begin
        miscompares++;
        $display("FAIL idle_hold[%0d] got data=%h valid=%b exp data=d2 valid=0",
                 i, data_out, valid_out);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] din [3]  = '{8'h30, 8'h6F, 8'h70};
    logic [7:0] dexp [3] = '{8'h53, 8'hE2, 8'h96};
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, din[i]);
      vectors++;
      if (valid_out !== 1'b1 || data_out !== dexp[i]) begin
        miscompares++;
        $display("FAIL gaps[%0d] got data=%h valid=%b exp data=%h valid=1",
                 i, data_out, valid_out, dexp[i]);
      end
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_frame_reload();
    int done_cnt = 0;
    int done_at = -1;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < LEN + 1; i++) begin
      drive(1'b0, 1'b1, 8'h00);
`ifdef EZLOGIC_FRAME_DONE_EN
      if (frame_done === 1'b1) begin done_cnt++; done_at = i; end
`endif
      vectors++;
      if (valid_out !== 1'b1 || data_out !== m_do) begin
        miscompares++;
        $display("FAIL frame_byte[%0d] got %h exp %h", i, data_out, m_do);
      end
    end
    vectors++;
    if (data_out !== 8'hD2) begin
      miscompares++;
      $display("FAIL frame_reload got %h exp d2", data_out);
    end
`ifdef EZLOGIC_FRAME_DONE_EN
    vectors++;
    if (done_cnt != 1 || done_at != LEN - 1) begin
      miscompares++;
      $display("FAIL frame_done got count=%0d at=%0d exp count=1 at=%0d",
               done_cnt, done_at, LEN - 1);
    end
    vectors++;
    if (frame_crc !== m_crc) begin
      miscompares++;
      $display("FAIL frame_crc got %h exp %h", frame_crc, m_crc);
    end
`else
    if (done_cnt != 0 || done_at != -1) begin end
`endif
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h30);
    drive(1'b0, 1'b1, 8'h6F);
    drive(1'b1, 1'b0, 8'h00);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_valid got %b exp 0", valid_out);
    end
    drive(1'b0, 1'b1, 8'h30);
    vectors++;
    if (valid_out !== 1'b1 || data_out !== 8'h53) begin
      miscompares++;
      $display("FAIL midrst_restart got data=%h valid=%b exp data=53 valid=1",
               data_out, valid_out);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b1, 8'h30);
    drive(1'b1, 1'b1, 8'h30);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rstprio_drop got valid=%b exp 0", valid_out);
    end
    drive(1'b0, 1'b1, 8'h30);
    vectors++;
    if (valid_out !== 1'b1 || data_out !== 8'h53) begin
      miscompares++;
      $display("FAIL rstprio_after got data=%h valid=%b exp data=53 valid=1",
               data_out, valid_out);
    end
  endtask

  task automatic test_random();
    logic r;
    logic v;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(99) < 2);
      v = ($urandom_range(99) < 75);
      drive(r, v, 8'($urandom));
      vectors++;
      if (valid_out !== m_vo || data_out !== m_do) begin
        miscompares++;
        $display("FAIL random[%0d] got data=%h valid=%b exp data=%h valid=%b",
                 i, data_out, valid_out, m_do, m_vo);
      end
`ifdef EZLOGIC_FRAME_DONE_EN
      vectors++;
      if (frame_done !== m_fd || frame_crc !== m_crc) begin
        miscompares++;
        $display("FAIL random_fd[%0d] got done=%b crc=%h exp done=%b crc=%h",
                 i, frame_done, frame_crc, m_fd, m_crc);
      end
`endif
    end
  endtask

  initial begin
    m_s = SEED; m_pos = 0; m_do = 8'h00; m_vo = 1'b0;
    m_fd = 1'b0; m_acc = 8'h00; m_crc = 8'h00;
    test_reset();
    test_back_to_back();
    test_single_idle();
    test_gaps();
    test_frame_reload();
    test_reset_mid_frame();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
